// File: rtl/bit_vector_index_streamer_if.sv
// Handshake bundle for the index streamer: vector in, one set-bit index per beat out.
// master = vector producer / index consumer side, slave = streamer side.
interface bit_vector_index_streamer_if #(
    parameter int VECTOR_SIZE = 16
);
    localparam int IDX_W = $clog2(VECTOR_SIZE);

    logic                   in_valid;
    logic                   in_ready;
    logic [VECTOR_SIZE-1:0] in_vector;
    logic                   out_valid;
    logic                   out_ready;
    logic [IDX_W-1:0]       out_index;
    logic                   out_last;
    logic                   out_empty;
    logic [IDX_W:0]         out_count;

    modport master (
        output in_valid, in_vector, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_empty, out_count
    );

    modport slave (
        input  in_valid, in_vector, out_ready,
        output in_ready, out_valid, out_index, out_last, out_empty, out_count
    );
endinterface

// File: rtl/bit_vector_index_streamer.sv
// Expands a bit vector into LSB-first set-bit indices; first beat 1 cycle after accept.
// Backpressure: beat held stable while out_ready=0; in_ready=0 until the final beat drains.
module bit_vector_index_streamer #(
    parameter int VECTOR_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    bit_vector_index_streamer_if.slave    bus
);
    localparam int IDX_W = $clog2(VECTOR_SIZE);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]             state;
    logic [VECTOR_SIZE-1:0] pend;
    logic [IDX_W:0]         cnt;
    logic                   empty_r;

    logic [IDX_W-1:0]       low_idx;
    logic [IDX_W:0]         in_pop;
    logic                   single;

    // Priority search from the top so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = VECTOR_SIZE - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        in_pop = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            in_pop = in_pop + (IDX_W + 1)'(bus.in_vector[i]);
        end
    end

    assign single = (pend != '0) && ((pend & (pend - VECTOR_SIZE'(1))) == '0);

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == STREAM);
    assign bus.out_index = low_idx;
    assign bus.out_last  = empty_r || single;
    assign bus.out_empty = empty_r;
    assign bus.out_count = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            cnt     <= '0;
            empty_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        pend    <= bus.in_vector;
                        cnt     <= in_pop;
                        empty_r <= (bus.in_vector == '0);
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        // x & (x-1) clears exactly the lowest set bit, i.e. out_index.
                        pend <= pend & (pend - VECTOR_SIZE'(1));
                        if (bus.out_last) begin
                            state   <= IDLE;
                            empty_r <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
